// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state encoding and width defaults for the divider and factorial controller
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Subtractor width: operand width plus the partial-remainder guard bit, rounded up to whole 4-bit slices
    function automatic int cla_width(input int w);
        return ((w + 1 + 3) / 4) * 4;
    endfunction

endpackage

// File: rtl/div_seq_sub_cla.sv
// rtl/div_seq_sub_cla.sv - adder built from chained 4-bit carry-lookahead slices
module sub_cla #(
    parameter int WIDTH = 36
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NS = WIDTH / 4;

    logic [NS:0] carry;

    assign carry[0] = ci;

    // Each slice resolves its internal carries in parallel; slices ripple into one another
    for (genvar k = 0; k < NS; k++) begin : g_slice
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;

        assign g = a[4*k +: 4] & b[4*k +: 4];
        assign p = a[4*k +: 4] ^ b[4*k +: 4];

        assign c[0] = carry[k];
        assign c[1] = g[0] | (p[0] & carry[k]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry[k]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & carry[k]);
        assign carry[k+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                          | (p[3] & p[2] & p[1] & g[0])
                          | (p[3] & p[2] & p[1] & p[0] & carry[k]);

        assign s[4*k +: 4] = p ^ c;
    end

    assign co = carry[NS];

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW    = cla_width(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_t state;
    div_state_t state_next;

    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             divisor_zero;
    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic [CW-1:0]    cla_a;
    logic [CW-1:0]    cla_b;
    logic [CW-1:0]    cla_s;
    logic             cla_co;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_bits;

    assign accept       = op_start && (state == ST_IDLE || state == ST_DONE);
    assign divisor_zero = (divisor == '0);
    assign last_step    = (cnt == '0);

    // Trial subtraction shifted - D as shifted + ~D + 1; carry-out high means no borrow
    assign shifted = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign cla_a   = CW'(shifted);
    assign cla_b   = ~CW'(d_reg);

    sub_cla #(.WIDTH(CW)) u_sub_cla (
        .a  (cla_a),
        .b  (cla_b),
        .ci (1'b1),
        .s  (cla_s),
        .co (cla_co)
    );

    assign r_next = cla_co ? cla_s[WIDTH:0] : shifted;
    assign q_next = {q_reg[WIDTH-2:0], cla_co};

    // Guard bits above the remainder are always zero once the trial is accepted
    assign unused_bits = ^{cla_s[CW-1:WIDTH+1], r_reg[WIDTH]};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs; a new start in DONE wins over op_clear
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (op_start) state_next = divisor_zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (op_start)      state_next = divisor_zero ? ST_DONE : ST_RUN;
                else if (op_clear) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: load on accepted start, iterate in RUN, publish results on completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            r_reg <= '0;
            q_reg <= dividend;
            d_reg <= divisor;
            cnt   <= CNT_W'(WIDTH - 1);
            if (divisor_zero) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end
        end else if (state == ST_RUN) begin
            r_reg <= r_next;
            q_reg <= q_next;
            cnt   <= cnt - 1'b1;
            if (last_step) begin
                quotient  <= q_next;
                remainder <= r_next[WIDTH-1:0];
                div_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_start = 1'b0;
    logic         op_clear = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_cmp = 0;
    int n_fail = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_start  (op_start),
        .op_clear  (op_clear),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Present a start for one edge; returns 1 ns after that edge
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    // Count edges until done, bounded; also count samples where busy was high
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %0b want 0", div_zero); end
        n_cmp++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_q: got %0h want 0", quotient); end
        n_cmp++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_r: got %0h want 0", remainder); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, bc;
        do_start(32'd100, 32'd7);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_edge0: got %0b want 1", busy); end
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 32) begin n_fail++; $display("FAIL basic_latency: got %0d want 32", cyc); end
        n_cmp++; if (bc !== 32) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 32", bc); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %0b want 0", busy); end
        n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %0d want 14", quotient); end
        n_cmp++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_r: got %0d want 2", remainder); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %0b want 0", div_zero); end
    endtask

    task automatic test_extremes();
        int cyc, bc;
        logic [W-1:0] qv [2];
        logic [W-1:0] dv [2];
        logic [W-1:0] eq [2];
        dv[0] = 32'hFFFF_FFFF; qv[0] = 32'h0000_0001; eq[0] = 32'hFFFF_FFFF;
        dv[1] = 32'hFFFF_FFFF; qv[1] = 32'hFFFF_FFFF; eq[1] = 32'h0000_0001;
        for (int i = 0; i < 2; i++) begin
            do_start(dv[i], qv[i]);
            wait_done(cyc, bc);
            n_cmp++; if (quotient !== eq[i]) begin n_fail++; $display("FAIL extreme_q[%0d]: got %0h want %0h", i, quotient, eq[i]); end
            n_cmp++; if (remainder !== '0) begin n_fail++; $display("FAIL extreme_r[%0d]: got %0h want 0", i, remainder); end
        end
    endtask

    task automatic test_small();
        int cyc, bc;
        do_start(32'd5, 32'd9);
        wait_done(cyc, bc);
        n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL small_q: got %0d want 0", quotient); end
        n_cmp++; if (remainder !== 32'd5) begin n_fail++; $display("FAIL small_r: got %0d want 5", remainder); end
        do_start(32'd0, 32'd3);
        wait_done(cyc, bc);
        n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL zero_dividend_q: got %0d want 0", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL zero_dividend_r: got %0d want 0", remainder); end
        // Clear back to IDLE; result must hold
        @(negedge clk); op_clear = 1'b1;
        @(posedge clk); #1; op_clear = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL clear_done: got %0b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %0b want 0", busy); end
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        do_start(32'd1234, 32'd0);
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 0) begin n_fail++; $display("FAIL dz_latency: got %0d want 0 extra edges", cyc); end
        n_cmp++; if (bc !== 0) begin n_fail++; $display("FAIL dz_busy: got %0d busy samples want 0", bc); end
        n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %0b want 1", div_zero); end
        n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_q: got %0h want ffffffff", quotient); end
        n_cmp++; if (remainder !== 32'd1234) begin n_fail++; $display("FAIL dz_r: got %0d want 1234", remainder); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        do_start(32'd100, 32'd7);
        n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL b2b_dz_held: got %0b want 1", div_zero); end
        repeat (9) @(posedge clk);
        do_start(32'd50, 32'd5);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_ignored_busy: got %0b want 1", busy); end
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 22) begin n_fail++; $display("FAIL b2b_ignored_latency: got %0d want 22", cyc); end
        n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL b2b_first_q: got %0d want 14", quotient); end
        n_cmp++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL b2b_first_r: got %0d want 2", remainder); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL b2b_first_dz: got %0b want 0", div_zero); end
        // Start from DONE with op_clear also high: start must win
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd5; op_start = 1'b1; op_clear = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0; op_clear = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %0b want 0", done); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_rise: got %0b want 1", busy); end
        n_cmp++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL b2b_q_held: got %0d want 14", quotient); end
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 32) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 32", cyc); end
        n_cmp++; if (quotient !== 32'd10) begin n_fail++; $display("FAIL b2b_second_q: got %0d want 10", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_second_r: got %0d want 0", remainder); end
    endtask

    task automatic test_reset_abort();
        int cyc, bc;
        do_start(32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0b want 0", done); end
        n_cmp++; if (quotient !== '0) begin n_fail++; $display("FAIL abort_q: got %0h want 0", quotient); end
        n_cmp++; if (remainder !== '0) begin n_fail++; $display("FAIL abort_r: got %0h want 0", remainder); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL abort_dz: got %0b want 0", div_zero); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %0b want 0", done); end
        @(negedge clk);
        reset_n = 1'b1;
        do_start(32'd9, 32'd2);
        wait_done(cyc, bc);
        n_cmp++; if (cyc !== 32) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 32", cyc); end
        n_cmp++; if (quotient !== 32'd4) begin n_fail++; $display("FAIL post_reset_q: got %0d want 4", quotient); end
        n_cmp++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL post_reset_r: got %0d want 1", remainder); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_small();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential unsigned restoring divider for the factorial datapath, and the inverse of the existing adder/multiplier path. It takes a dividend and divisor through a start/done handshake and produces one quotient bit per clock. Its trial subtraction uses a chained 4-bit carry-lookahead subtractor. The block sits beside the factorial multiplier so results can be scaled or checked by division without a combinational divider.

## Interface
- WIDTH, 32: operand width in bits. Must be a multiple of 4 and at least 4.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- op_start  input  1  request a division. Sampled only in IDLE or DONE.
- op_clear  input  1  return from DONE to IDLE
- dividend  input  WIDTH  unsigned dividend, captured on the accepted op_start edge
- divisor  input  WIDTH  unsigned divisor, captured on the accepted op_start edge
- quotient  output  WIDTH  result quotient. Valid while done=1.
- remainder  output  WIDTH  result remainder. Valid while done=1.
- busy  output  1  division in progress
- done  output  1  result valid. Held until op_clear or the next accepted op_start.
- div_zero  output  1  the last accepted operation had divisor = 0. Valid with done.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE + op_start: divisor≠0 → RUN; divisor=0 → DONE.
  - RUN: stays for exactly WIDTH cycles, then → DONE.
  - DONE + op_start: accepted exactly as from IDLE. op_start takes priority over op_clear when both are high.
  - DONE + op_clear (op_start low) → IDLE.
- op_start in RUN is ignored. It is neither queued nor able to corrupt the running operation.
- Registers:
  - R: WIDTH+1-bit partial remainder, cleared on start.
  - Q: WIDTH-bit shift register, loaded with dividend on start.
  - D: divisor latch.
  - cnt: down counter, loaded with WIDTH-1.
- Each RUN cycle:
  - shifted = {R[WIDTH-1:0], Q[WIDTH-1]}
  - trial = shifted − {0, D}, WIDTH+1 bits, computed as shifted + ~D + 1 with carry-in 1.
  - If carry-out = 1 (no borrow): R ← trial and Q ← {Q[WIDTH-2:0], 1].
  - Otherwise: R ← shifted and Q ← {Q[WIDTH-2:0], 0}.
  - cnt decrements. The RUN cycle with cnt=0 is the last one.
- On entering DONE: quotient ← Q, remainder ← R[WIDTH-1:0], div_zero ← 0.
- Divide by zero: quotient = all ones, remainder = dividend, div_zero = 1. No RUN cycles are spent.
- quotient, remainder and div_zero hold their values in IDLE until the next completion.

## Timing
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - busy, done, div_zero = 0.
  - quotient, remainder, R, Q, D, cnt = 0.
- Reset asserted mid-RUN aborts the operation immediately. No done is produced.
- Let edge 0 be the edge where op_start is accepted.
  - busy=1 from edge 0 through edge WIDTH.
  - done=1 after edge WIDTH, giving a latency of WIDTH clocks (32 at default).
- Divisor 0: done=1 and div_zero=1 after edge 0, a latency of 1 clock.
- Back-to-back operation: op_start asserted while done=1 is accepted on that edge.
  - done drops and busy rises after the same edge.
  - The previous result stays on quotient/remainder until the new completion.
- Throughput: one division per WIDTH+1 cycles with back-to-back starts, which includes the DONE cycle.

## Structure
- Shared package: state encoding constants (IDLE, RUN, DONE) and the default WIDTH, shared with the factorial controller.
- Sub-module sub_cla, parameterised WIDTH+1 rounded up to a multiple of 4:
  - Chains 4-bit carry-lookahead slices.
  - Inputs a, b, ci; outputs s, co.
  - The divider drives b with inverted D and ci=1.
- The FSM and datapath registers live in div_seq. No other sub-modules.

## Test plan
- 100 / 7, WIDTH=32 → after 32 busy cycles: done=1, quotient=14, remainder=2, div_zero=0.
- 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0. Also 0xFFFFFFFF / 0xFFFFFFFF → quotient=1, remainder=0.
- 5 / 9 → quotient=0, remainder=5. Also 0 / 3 → quotient=0, remainder=0.
- 1234 / 0 → one cycle later: done=1, div_zero=1, quotient=0xFFFFFFFF, remainder=1234. busy never rises.
- Start 100/7, then pulse op_start with 50/5 at cycle 10 of RUN → ignored. Result is still 14 r 2 at cycle 32. Then op_start with 50/5 during DONE → 10 r 0 after 32 more cycles.
- Start 1000/3, drop reset_n at cycle 15 → all outputs 0 and state IDLE immediately. After release, 9/2 → quotient=4, remainder=1.
